// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: memory-wait FSM states
// and the zero-register index that can never create a dependency.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker: counts cycles spent waiting on mem_ready and
// latches a sticky timeout error that only reset clears.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      mem_req_MEM,
  input  logic      mem_ready,
  output logic      mem_freeze,
  output logic      mem_error,
  output hz_state_t state
);

  localparam logic [7:0] TIMEOUT_V = 8'(MEM_TIMEOUT);

  logic [7:0] wait_cnt;

  // The counter holds the number of MEM_WAIT cycles already spent, so it
  // reads 1 in the first waiting cycle after the stalled request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_error <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_V) begin
            state     <= ERROR;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state     <= ERROR;
          mem_error <= 1'b1;
        end
      endcase
    end
  end

  assign mem_freeze = (state == RUN && mem_req_MEM && !mem_ready) ||
                      (state == MEM_WAIT && !mem_ready) ||
                      (state == ERROR);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch
// flush and load-use bubble. Optional counters enabled by HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs2_ID,
  input  logic             mem_read_EX,
  input  logic [4:0]       regWrite_EX,
  input  logic             br_taken_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic      mem_freeze;
  logic      frozen;
  logic      load_use;
  logic      do_flush;
  logic      do_bubble;
  hz_state_t state;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .mem_req_MEM(mem_req_MEM),
    .mem_ready  (mem_ready),
    .mem_freeze (mem_freeze),
    .mem_error  (mem_error),
    .state      (state)
  );

  // ERROR must freeze even if the handshake inputs look idle.
  assign frozen = mem_freeze || (state == ERROR);

  assign load_use = mem_read_EX && (regWrite_EX != XZR) &&
                    ((regWrite_EX == rs1_ID) ||
                     (uses_rs2_ID && (regWrite_EX == rs2_ID)));

  assign do_flush  = !frozen && br_taken_EX;
  assign do_bubble = !frozen && !br_taken_EX && load_use;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    if (!reset) begin
      if (frozen) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (do_flush) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (do_bubble) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Saturating event counters; a freeze cycle counts only as a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      bubble_cnt   <= '0;
      flush_cnt    <= '0;
    end else begin
      if (frozen && stall_cycles != '1) stall_cycles <= stall_cycles + ONE;
      if (do_bubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + ONE;
      if (do_flush && flush_cnt != '1) flush_cnt <= flush_cnt + ONE;
    end
  end
`else
  assign stall_cycles = '0;
  assign bubble_cnt   = '0;
  assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Control vector order: pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb
  localparam logic [6:0] RUNV  = 7'b1101011;
  localparam logic [6:0] FRZV  = 7'b0000000;
  localparam logic [6:0] LUV   = 7'b0001111;
  localparam logic [6:0] BRV   = 7'b1111111;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs1_ID, rs2_ID, regWrite_EX;
  logic             uses_rs2_ID, mem_read_EX, br_taken_EX, mem_req_MEM, mem_ready;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles, bubble_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs2_ID(uses_rs2_ID),
    .mem_read_EX(mem_read_EX), .regWrite_EX(regWrite_EX),
    .br_taken_EX(br_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .mem_error(mem_error), .stall_cycles(stall_cycles),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Model: an access is outstanding from an unanswered request until ready.
  bit      m_started = 1'b0;
  bit      m_err = 1'b0;
  bit      m_waiting = 1'b0;
  int      m_waited = 0;
  longint  m_stall = 0, m_bub = 0, m_flush = 0;

  function automatic bit m_lu();
    return mem_read_EX && regWrite_EX != 5'd31 &&
           (regWrite_EX == rs1_ID || (uses_rs2_ID && regWrite_EX == rs2_ID));
  endfunction

  function automatic bit m_freeze();
    return m_err || (!mem_ready && (mem_req_MEM || m_waiting));
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (reset)           return RUNV;
    if (m_freeze())      return FRZV;
    if (br_taken_EX)     return BRV;
    if (m_lu())          return LUV;
    return RUNV;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_started <= 1'b1;
      m_err     <= 1'b0;
      m_waiting <= 1'b0;
      m_waited  <= 0;
      m_stall   <= 0;
      m_bub     <= 0;
      m_flush   <= 0;
    end else begin
      if (!m_err) begin
        if (m_freeze()) begin
          if (!m_waiting) begin
            m_waiting <= 1'b1;
            m_waited  <= 1;
          end else if (m_waited == TMO) begin
            m_err <= 1'b1;
          end else begin
            m_waited <= m_waited + 1;
          end
        end else begin
          m_waiting <= 1'b0;
        end
      end
      if (m_freeze())       m_stall <= m_stall + 1;
      else if (br_taken_EX) m_flush <= m_flush + 1;
      else if (m_lu())      m_bub <= m_bub + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      logic [6:0] act;
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
      total++;
      if (act !== m_ctrl()) begin
        bad++;
        $display("[TB] FAIL model_ctrl t=%0t got=%b want=%b", $time, act, m_ctrl());
      end
      total++;
      if (mem_error !== m_err) begin
        bad++;
        $display("[TB] FAIL model_err t=%0t got=%b want=%b", $time, mem_error, m_err);
      end
      total++;
      if (stall_cycles !== (PERF ? CNT_W'(m_stall) : '0) ||
          bubble_cnt   !== (PERF ? CNT_W'(m_bub)   : '0) ||
          flush_cnt    !== (PERF ? CNT_W'(m_flush) : '0)) begin
        bad++;
        $display("[TB] FAIL model_cnt t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                 stall_cycles, bubble_cnt, flush_cnt,
                 PERF ? m_stall : 0, PERF ? m_bub : 0, PERF ? m_flush : 0);
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u2, input logic mr, input logic [4:0] rd,
                               input logic br, input logic req, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; rs1_ID = rs1; rs2_ID = rs2; uses_rs2_ID = u2;
    mem_read_EX = mr; regWrite_EX = rd; br_taken_EX = br;
    mem_req_MEM = req; mem_ready = rdy;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    @(negedge clk);
    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rs1_ID = '0; rs2_ID = '0; uses_rs2_ID = 1'b0; mem_read_EX = 1'b0;
    regWrite_EX = '0; br_taken_EX = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;

    idle(1'b1);
    checkOutput("reset_ctrl", RUNV);
    checkValue("reset_err", longint'(mem_error), 0);
    checkValue("reset_stall", longint'(stall_cycles), 0);
    idle(1'b0);
    checkOutput("idle_run", RUNV);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkOutput("loaduse_rs1", LUV);
    idle(1'b0);
    checkOutput("loaduse_next", RUNV);
    applyStimulus(1'b0, 5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    checkOutput("xzr_nohazard", RUNV);

    applyStimulus(1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_unused", RUNV);
    applyStimulus(1'b0, 5'd0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("rs2_used", LUV);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_over_lu", BRV);
    applyStimulus(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("branch_only", BRV);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("memwait_frozen", FRZV);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("memwait_release", RUNV);
    idle(1'b0);
    checkOutput("memwait_after", RUNV);
    checkValue("stall_after_wait", longint'(stall_cycles), PERF ? 3 : 0);
    checkValue("bubble_total", longint'(bubble_cnt), PERF ? 2 : 0);
    checkValue("flush_total", longint'(flush_cnt), PERF ? 2 : 0);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("req_ready_same", RUNV);
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    checkOutput("freeze_masks", FRZV);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("freeze_release", RUNV);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("timeout_frozen", FRZV);
    end
    checkValue("timeout_err_pre", longint'(mem_error), 0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("error_frozen", FRZV);
    checkValue("timeout_err_set", longint'(mem_error), 1);
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("error_sticky", FRZV);
    checkValue("error_held", longint'(mem_error), 1);
    idle(1'b1);
    checkOutput("error_reset", RUNV);
    idle(1'b0);
    checkOutput("error_cleared", RUNV);
    checkValue("error_err_clr", longint'(mem_error), 0);
    checkValue("error_cnt_clr", longint'(stall_cycles), 0);

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("midwait_frozen", FRZV);
    end
    idle(1'b1);
    checkOutput("midwait_reset", RUNV);
    idle(1'b0);
    checkOutput("midwait_run", RUNV);
    checkValue("midwait_stall_clr", longint'(stall_cycles), 0);
    checkValue("midwait_err", longint'(mem_error), 0);

    idle(1'b0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
